cruise_speed_fsm: RTL and testbench

//  Upstream command stage for the 7-bit set-speed up/down counter. Decodes driver

---
 rtl/cruise_speed_if.sv | 29 ++
 rtl/cruise_speed_fsm.sv | 151 +++++++++++++++
 tb/tb_cruise_speed_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cruise_speed_if.sv
// Signal bundle between the cruise driver controls/counter and the command stage.
// master drives controls and the counter feedback; slave is the command FSM.
interface cruise_speed_if #(
   parameter int WIDTH = 7
);
   logic             cruise_on;
   logic             set;
   logic             resume;
   logic             accel;
   logic             coast;
   logic             brake;
   logic [WIDTH-1:0] speed_in;
   logic [WIDTH-1:0] cruise_speed;
   logic             cnt_enable;
   logic             cnt_mode;
   logic [WIDTH-1:0] cnt_load;
   logic             active;
   logic [2:0]       state;

   modport master (
      output cruise_on, set, resume, accel, coast, brake, speed_in, cruise_speed,
      input  cnt_enable, cnt_mode, cnt_load, active, state
   );

   modport slave (
      input  cruise_on, set, resume, accel, coast, brake, speed_in, cruise_speed,
      output cnt_enable, cnt_mode, cnt_load, active, state
   );
endinterface

// File: rtl/cruise_speed_fsm.sv
// Cruise-control command stage: turns driver controls into set-speed counter
// commands ({enable,mode}: 00 hold, 01 load, 11 up, 10 down) with paced steps.
module cruise_speed_fsm #(
   parameter int WIDTH     = 7,
   parameter int MIN_SPEED = 40,
   parameter int MAX_SPEED = 120,
   parameter int STEP_DIV  = 4
) (
   input  logic         clk,
   input  logic         clear,
   cruise_speed_if.slave bus
);
   typedef enum logic [2:0] {
      OFF     = 3'd0,
      IDLE    = 3'd1,
      CRUISE  = 3'd2,
      ACCEL   = 3'd3,
      DECEL   = 3'd4,
      STANDBY = 3'd5
   } state_t;

   localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_SPEED);
   localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_SPEED);
   localparam logic [7:0]       STEP_LAST = 8'(STEP_DIV - 1);

   state_t           state_reg, state_next;
   logic [7:0]       presc_reg, presc_next;

   // Command decided this cycle, presented on the outputs one cycle later.
   logic             pend_en_reg, pend_en_next;
   logic             pend_mode_reg, pend_mode_next;
   logic [WIDTH-1:0] pend_load_reg, pend_load_next;

   logic             cnt_enable_reg, cnt_mode_reg, active_reg;
   logic [WIDTH-1:0] cnt_load_reg;

   logic             speed_ok, can_up, can_down;
   logic [WIDTH-1:0] load_val;
   logic             load_req, up_req, down_req;

   assign speed_ok = (bus.speed_in >= MIN_V);
   assign load_val = (bus.speed_in > MAX_V) ? MAX_V : bus.speed_in;
   assign can_up   = (bus.cruise_speed < MAX_V);
   assign can_down = (bus.cruise_speed > MIN_V);

   always_comb begin
      state_next = state_reg;
      presc_next = presc_reg;
      load_req   = 1'b0;
      up_req     = 1'b0;
      down_req   = 1'b0;

      if (!bus.cruise_on) begin
         state_next = OFF;
      end else begin
         case (state_reg)
            OFF: state_next = IDLE;
            IDLE: begin
               if (!bus.brake && bus.set && speed_ok) begin
                  load_req   = 1'b1;
                  state_next = CRUISE;
               end
            end
            CRUISE: begin
               if (bus.brake) begin
                  state_next = STANDBY;
               end else if (bus.set && speed_ok) begin
                  load_req = 1'b1;
               end else if (bus.resume) begin
                  state_next = CRUISE;
               end else if (bus.accel && !bus.coast) begin
                  state_next = ACCEL;
                  presc_next = 8'd0;
                  up_req     = can_up;
               end else if (bus.coast && !bus.accel) begin
                  state_next = DECEL;
                  presc_next = 8'd0;
                  down_req   = can_down;
               end
            end
            ACCEL, DECEL: begin
               if (bus.brake) begin
                  state_next = STANDBY;
               end else if (bus.set && speed_ok) begin
                  load_req   = 1'b1;
                  state_next = CRUISE;
               end else if ((state_reg == ACCEL) ? (!bus.accel || bus.coast)
                                                 : (!bus.coast || bus.accel)) begin
                  state_next = CRUISE;
               end else if (presc_reg >= STEP_LAST) begin
                  // A saturated step still consumes its slot.
                  presc_next = 8'd0;
                  up_req     = (state_reg == ACCEL) && can_up;
                  down_req   = (state_reg == DECEL) && can_down;
               end else begin
                  presc_next = presc_reg + 8'd1;
               end
            end
            STANDBY: begin
               if (bus.brake) begin
                  state_next = STANDBY;
               end else if (bus.set && speed_ok) begin
                  load_req   = 1'b1;
                  state_next = CRUISE;
               end else if (bus.resume) begin
                  state_next = CRUISE;
               end
            end
            default: state_next = OFF;
         endcase
      end

      pend_en_next   = up_req || down_req;
      pend_mode_next = up_req || load_req;
      pend_load_next = load_req ? load_val : '0;
      if (load_req) begin
         pend_en_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_reg      <= OFF;
         presc_reg      <= 8'd0;
         pend_en_reg    <= 1'b0;
         pend_mode_reg  <= 1'b0;
         pend_load_reg  <= '0;
         cnt_enable_reg <= 1'b0;
         cnt_mode_reg   <= 1'b0;
         cnt_load_reg   <= '0;
         active_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         presc_reg      <= presc_next;
         pend_en_reg    <= pend_en_next;
         pend_mode_reg  <= pend_mode_next;
         pend_load_reg  <= pend_load_next;
         cnt_enable_reg <= pend_en_reg;
         cnt_mode_reg   <= pend_mode_reg;
         cnt_load_reg   <= pend_load_reg;
         active_reg     <= (state_reg == CRUISE) || (state_reg == ACCEL) ||
                           (state_reg == DECEL);
      end
   end

   assign bus.cnt_enable = cnt_enable_reg;
   assign bus.cnt_mode   = cnt_mode_reg;
   assign bus.cnt_load   = cnt_load_reg;
   assign bus.active     = active_reg;
   assign bus.state      = state_reg;
endmodule

// File: tb/tb_cruise_speed_fsm.sv
// Directed bench for cruise_speed_fsm with a behavioural set-speed counter
// closing the cruise_speed feedback loop.
module tb_cruise_speed_fsm;
   logic clk = 1'b0;
   logic clear;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [6:0] cnt_model = 7'd0;

   cruise_speed_if #(.WIDTH(7)) bus ();

   cruise_speed_fsm #(
      .WIDTH(7), .MIN_SPEED(40), .MAX_SPEED(120), .STEP_DIV(4)
   ) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.cruise_speed = cnt_model;

   always @(posedge clk) begin
      case ({bus.cnt_enable, bus.cnt_mode})
         2'b01:   cnt_model <= bus.cnt_load;
         2'b11:   cnt_model <= cnt_model + 7'd1;
         2'b10:   cnt_model <= cnt_model - 7'd1;
         default: cnt_model <= cnt_model;
      endcase
   end

   typedef struct {
      logic       on, st, rs, ac, cs, bk;
      logic [6:0] spd;
      logic [2:0] est;
      logic       een, emd;
      logic [6:0] eld;
      logic       eact;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic on, st, rs, ac, cs, bk, input logic [6:0] spd,
                               input logic [2:0] est, input logic een, emd,
                               input logic [6:0] eld, input logic eact);
      vec_t v;
      v.on = on; v.st = st; v.rs = rs; v.ac = ac; v.cs = cs; v.bk = bk; v.spd = spd;
      v.est = est; v.een = een; v.emd = emd; v.eld = eld; v.eact = eact;
      return v;
   endfunction

   task automatic drive(input logic on, st, rs, ac, cs, bk, input logic [6:0] spd);
      bus.cruise_on = on; bus.set = st; bus.resume = rs;
      bus.accel = ac; bus.coast = cs; bus.brake = bk; bus.speed_in = spd;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int st, input int en, input int md,
                           input int ld, input int act);
      chk({tag, " state"}, int'(bus.state), st);
      chk({tag, " en"}, int'(bus.cnt_enable), en);
      chk({tag, " mode"}, int'(bus.cnt_mode), md);
      chk({tag, " load"}, int'(bus.cnt_load), ld);
      chk({tag, " active"}, int'(bus.active), act);
   endtask

   initial begin
      int ups, downs, first_up, last_up;

      //           on st rs ac cs bk spd   st en md ld   act
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 7'd0,   1, 0, 0, 7'd0,   0);
      tbl[1]  = mk(1, 1, 0, 0, 0, 0, 7'd55,  2, 0, 0, 7'd0,   0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 7'd55,  2, 0, 1, 7'd55,  1);
      tbl[3]  = mk(1, 0, 0, 0, 0, 0, 7'd55,  2, 0, 0, 7'd0,   1);
      tbl[4]  = mk(1, 0, 0, 0, 0, 1, 7'd55,  5, 0, 0, 7'd0,   1);
      tbl[5]  = mk(1, 0, 1, 0, 0, 1, 7'd55,  5, 0, 0, 7'd0,   0);
      tbl[6]  = mk(1, 0, 1, 0, 0, 0, 7'd55,  2, 0, 0, 7'd0,   0);
      tbl[7]  = mk(1, 0, 0, 0, 0, 0, 7'd55,  2, 0, 0, 7'd0,   1);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 7'd55,  2, 0, 0, 7'd0,   1);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 7'd55,  0, 0, 0, 7'd0,   1);
      tbl[10] = mk(1, 0, 0, 0, 0, 0, 7'd55,  1, 0, 0, 7'd0,   0);
      tbl[11] = mk(1, 1, 0, 0, 0, 0, 7'd30,  1, 0, 0, 7'd0,   0);
      tbl[12] = mk(1, 0, 0, 0, 0, 0, 7'd30,  1, 0, 0, 7'd0,   0);
      tbl[13] = mk(1, 1, 0, 0, 0, 0, 7'd127, 2, 0, 0, 7'd0,   0);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 7'd127, 2, 0, 1, 7'd120, 1);
      tbl[15] = mk(1, 0, 0, 0, 0, 0, 7'd127, 2, 0, 0, 7'd0,   1);
      tbl[16] = mk(1, 0, 0, 0, 0, 1, 7'd70,  5, 0, 0, 7'd0,   1);
      tbl[17] = mk(1, 1, 0, 0, 0, 0, 7'd70,  2, 0, 0, 7'd0,   0);
      tbl[18] = mk(1, 0, 0, 0, 0, 0, 7'd70,  2, 0, 1, 7'd70,  1);
      tbl[19] = mk(1, 0, 0, 0, 0, 0, 7'd70,  2, 0, 0, 7'd0,   1);

      clear = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 7'd0);
      repeat (3) @(negedge clk);
      chk_outs("reset", 0, 0, 0, 0, 0);
      clear = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].on, tbl[i].st, tbl[i].rs, tbl[i].ac, tbl[i].cs, tbl[i].bk, tbl[i].spd);
         @(negedge clk);
         chk_outs($sformatf("row%0d", i), tbl[i].est, tbl[i].een, tbl[i].emd,
                  tbl[i].eld, tbl[i].eact);
         $display("row %0d: state=%0d en=%0d mode=%0d load=%0d active=%0d", i,
                  bus.state, bus.cnt_enable, bus.cnt_mode, bus.cnt_load, bus.active);
      end
      chk("standby set speed", int'(cnt_model), 70);

      // Accel pacing from 60: steps one cycle after entry, then every 4 cycles.
      drive(1, 1, 0, 0, 0, 0, 7'd60);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 7'd60);
      repeat (3) @(negedge clk);
      chk("speed before accel", int'(cnt_model), 60);
      ups = 0; first_up = -1; last_up = -1;
      drive(1, 0, 0, 1, 0, 0, 7'd60);
      for (int i = 0; i < 12; i++) begin
         if (i == 9) drive(1, 0, 0, 0, 0, 0, 7'd60);
         @(negedge clk);
         if (i == 0) chk("accel entry state", int'(bus.state), 3);
         if (bus.cnt_enable && bus.cnt_mode) begin
            ups++;
            if (first_up < 0) first_up = i;
            last_up = i;
         end
      end
      $display("accel hold: ups=%0d first=%0d last=%0d speed=%0d", ups, first_up, last_up, cnt_model);
      chk("accel up count", ups, 3);
      chk("accel first up", first_up, 1);
      chk("accel last up", last_up, 9);
      chk("accel release state", int'(bus.state), 2);
      chk("accel release en", int'(bus.cnt_enable), 0);
      chk("accel final speed", int'(cnt_model), 63);

      // Upper saturation at 120.
      drive(1, 1, 0, 0, 0, 0, 7'd119);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 7'd119);
      repeat (3) @(negedge clk);
      ups = 0;
      drive(1, 0, 0, 1, 0, 0, 7'd119);
      for (int i = 0; i < 15; i++) begin
         if (i == 12) drive(1, 0, 0, 0, 0, 0, 7'd119);
         @(negedge clk);
         if (bus.cnt_enable && bus.cnt_mode) ups++;
      end
      $display("accel sat: ups=%0d speed=%0d", ups, cnt_model);
      chk("sat up count", ups, 1);
      chk("sat max speed", int'(cnt_model), 120);

      // Lower saturation at 40.
      drive(1, 1, 0, 0, 0, 0, 7'd41);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 7'd41);
      repeat (3) @(negedge clk);
      chk("speed before coast", int'(cnt_model), 41);
      downs = 0;
      drive(1, 0, 0, 0, 1, 0, 7'd41);
      for (int i = 0; i < 15; i++) begin
         if (i == 12) drive(1, 0, 0, 0, 0, 0, 7'd41);
         @(negedge clk);
         if (i == 0) chk("coast entry state", int'(bus.state), 4);
         if (bus.cnt_enable && !bus.cnt_mode) downs++;
      end
      $display("coast sat: downs=%0d speed=%0d", downs, cnt_model);
      chk("sat down count", downs, 1);
      chk("sat min speed", int'(cnt_model), 40);

      // Clear while an accel step is pending.
      drive(1, 0, 0, 1, 0, 0, 7'd41);
      @(negedge clk);
      chk("pre-clear state", int'(bus.state), 3);
      clear = 1'b1;
      @(negedge clk);
      chk_outs("clear", 0, 0, 0, 0, 0);
      $display("clear: state=%0d en=%0d mode=%0d", bus.state, bus.cnt_enable, bus.cnt_mode);
      clear = 1'b0;

      // cruise_on dropped while cruising.
      drive(1, 0, 0, 0, 0, 0, 7'd50);
      @(negedge clk);
      chk("reengage idle", int'(bus.state), 1);
      drive(1, 1, 0, 0, 0, 0, 7'd50);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 7'd50);
      repeat (2) @(negedge clk);
      chk("reengage cruise", int'(bus.state), 2);
      chk("reengage speed", int'(cnt_model), 50);
      drive(0, 0, 0, 0, 0, 0, 7'd50);
      @(negedge clk);
      chk("cruise_on off state", int'(bus.state), 0);
      @(negedge clk);
      chk("cruise_on off active", int'(bus.active), 0);
      $display("off: state=%0d active=%0d", bus.state, bus.active);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
